// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of request, data and sink signals around the shared 4:1 mux.
// The slave side is the arbiter; the master side holds the requesters and the sink.
interface mux4_rr_arbiter_if #(
   parameter int IW = 8
);
   logic [3:0]    i_Req;
   logic [3:0]    i_Last;
   logic [IW-1:0] i_Data1;
   logic [IW-1:0] i_Data2;
   logic [IW-1:0] i_Data3;
   logic [IW-1:0] i_Data4;
   logic          i_Ready;
   logic [3:0]    o_Gnt;
   logic [1:0]    o_Select;
   logic          o_Valid;
   logic [IW-1:0] o_Data;
   logic [1:0]    o_Src;
   logic          o_Timeout;

   modport slave (
      input  i_Req, i_Last, i_Data1, i_Data2, i_Data3, i_Data4, i_Ready,
      output o_Gnt, o_Select, o_Valid, o_Data, o_Src, o_Timeout
   );

   modport master (
      output i_Req, i_Last, i_Data1, i_Data2, i_Data3, i_Data4, i_Ready,
      input  o_Gnt, o_Select, o_Valid, o_Data, o_Src, o_Timeout
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 datapath mux with a registered
// valid/ready output stage and a hold watchdog that evicts stalled owners.
//
// state | meaning
// IDLE  | no owner; next requester chosen from ptr onwards, one bubble after each release
// BUSY  | owner in select_q may push beats until a last beat, a request drop or a timeout
module mux4_rr_arbiter #(
   parameter int IW       = 8,
   parameter int MAX_HOLD = 16
) (
   input logic              i_Clk,
   input logic              i_Rst_n,
   mux4_rr_arbiter_if.slave bus
);

   localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [1:0]    select_q, select_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic          valid_q, valid_d;
   logic [IW-1:0] data_q, data_d;
   logic [1:0]    src_q, src_d;
   logic          timeout_q, timeout_d;

   logic [1:0]    winner;
   logic          found;
   logic [IW-1:0] mux_data;
   logic          slot_free;
   logic          accept;
   logic          release_now;

   always_comb begin
      winner = ptr_q;
      found  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] idx;
         idx = ptr_q + 2'(i);
         if (!found && bus.i_Req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      mux_data = bus.i_Data1;
      case (select_q)
         2'd0: mux_data = bus.i_Data1;
         2'd1: mux_data = bus.i_Data2;
         2'd2: mux_data = bus.i_Data3;
         2'd3: mux_data = bus.i_Data4;
         default: mux_data = bus.i_Data1;
      endcase
   end

   assign slot_free   = !valid_q || bus.i_Ready;
   assign accept      = (state_q == ST_BUSY) && bus.i_Req[select_q] && slot_free;
   // A drop of the owner's request counts as a release even with no beat.
   assign release_now = (state_q == ST_BUSY) &&
                        ((accept && bus.i_Last[select_q]) || !bus.i_Req[select_q]);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      select_d   = select_q;
      hold_cnt_d = hold_cnt_q;
      valid_d    = valid_q;
      data_d     = data_q;
      src_d      = src_q;
      timeout_d  = 1'b0;

      if (accept) begin
         valid_d = 1'b1;
         data_d  = mux_data;
         src_d   = select_q;
      end else if (valid_q && bus.i_Ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               gnt_d      = 4'b0001 << winner;
               select_d   = winner;
               hold_cnt_d = '0;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (release_now) begin
               gnt_d   = 4'b0000;
               ptr_d   = select_q + 2'd1;
               state_d = ST_IDLE;
            end else if (hold_cnt_q == HOLD_LIM) begin
               gnt_d     = 4'b0000;
               ptr_d     = select_q + 2'd1;
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 2'd0;
         gnt_q      <= 4'b0000;
         select_q   <= 2'd0;
         hold_cnt_q <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         src_q      <= 2'd0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         select_q   <= select_d;
         hold_cnt_q <= hold_cnt_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         src_q      <= src_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.o_Gnt     = gnt_q;
   assign bus.o_Select  = select_q;
   assign bus.o_Valid   = valid_q;
   assign bus.o_Data    = data_q;
   assign bus.o_Src     = src_q;
   assign bus.o_Timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one DUT with the default hold limit and
// one with a short limit for the watchdog scenario.
module tb_mux4_rr_arbiter;

   logic clk_sys;
   logic rst_b;
   int   n_checks;
   int   n_fail;

   mux4_rr_arbiter_if #(.IW(8)) bus_a ();
   mux4_rr_arbiter_if #(.IW(8)) bus_b ();

   mux4_rr_arbiter #(.IW(8), .MAX_HOLD(16)) u_dut_a (
      .i_Clk   (clk_sys),
      .i_Rst_n (rst_b),
      .bus     (bus_a)
   );

   mux4_rr_arbiter #(.IW(8), .MAX_HOLD(4)) u_dut_b (
      .i_Clk   (clk_sys),
      .i_Rst_n (rst_b),
      .bus     (bus_b)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle_inputs();
      bus_a.i_Req = 4'b0; bus_a.i_Last = 4'b0; bus_a.i_Ready = 1'b0;
      bus_a.i_Data1 = 8'h00; bus_a.i_Data2 = 8'h00; bus_a.i_Data3 = 8'h00; bus_a.i_Data4 = 8'h00;
      bus_b.i_Req = 4'b0; bus_b.i_Last = 4'b0; bus_b.i_Ready = 1'b0;
      bus_b.i_Data1 = 8'h00; bus_b.i_Data2 = 8'h00; bus_b.i_Data3 = 8'h00; bus_b.i_Data4 = 8'h00;
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      idle_inputs();
      tick();
      tick();
      #2;
      rst_b = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({bus_a.o_Gnt, bus_a.o_Select, bus_a.o_Valid, bus_a.o_Data, bus_a.o_Src, bus_a.o_Timeout} !== 18'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: gnt=%b sel=%0d vld=%b data=%h src=%0d to=%b, required all zero",
                  bus_a.o_Gnt, bus_a.o_Select, bus_a.o_Valid, bus_a.o_Data, bus_a.o_Src, bus_a.o_Timeout);
      end
   endtask

   task automatic test_single();
      do_reset();
      bus_a.i_Req = 4'b0001; bus_a.i_Last = 4'b0001; bus_a.i_Data1 = 8'h5A; bus_a.i_Ready = 1'b1;
      tick();
      n_checks++;
      if (bus_a.o_Gnt !== 4'b0001 || bus_a.o_Select !== 2'd0 || bus_a.o_Valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_grant: gnt=%b sel=%0d vld=%b, required 0001/0/0", bus_a.o_Gnt, bus_a.o_Select, bus_a.o_Valid);
      end
      tick();
      n_checks++;
      if (bus_a.o_Valid !== 1'b1 || bus_a.o_Data !== 8'h5A || bus_a.o_Src !== 2'd0 || bus_a.o_Gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_beat: vld=%b data=%h src=%0d gnt=%b, required 1/5a/0/0000",
                  bus_a.o_Valid, bus_a.o_Data, bus_a.o_Src, bus_a.o_Gnt);
      end
      bus_a.i_Req = 4'b0000;
      tick();
      n_checks++;
      if (bus_a.o_Valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_drain: vld=%b, required 0", bus_a.o_Valid);
      end
      // pointer moved to 1: with all requesting, requester 1 wins next
      bus_a.i_Req = 4'b1111; bus_a.i_Last = 4'b1111;
      tick();
      n_checks++;
      if (bus_a.o_Gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL single_ptr_next: gnt=%b, required 0010", bus_a.o_Gnt);
      end
      bus_a.i_Req = 4'b0000;
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_data [4];
      exp_data[0] = 8'hA0; exp_data[1] = 8'hA1; exp_data[2] = 8'hA2; exp_data[3] = 8'hA3;
      do_reset();
      bus_a.i_Data1 = 8'hA0; bus_a.i_Data2 = 8'hA1; bus_a.i_Data3 = 8'hA2; bus_a.i_Data4 = 8'hA3;
      bus_a.i_Req = 4'b1111; bus_a.i_Last = 4'b1111; bus_a.i_Ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic [1:0] w;
         w = 2'(i % 4);
         tick();
         n_checks++;
         if (bus_a.o_Gnt !== (4'b0001 << w) || bus_a.o_Select !== w) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: gnt=%b sel=%0d, required %b/%0d", i, bus_a.o_Gnt, bus_a.o_Select, 4'b0001 << w, w);
         end
         tick();
         n_checks++;
         if (bus_a.o_Gnt !== 4'b0000 || bus_a.o_Valid !== 1'b1 || bus_a.o_Src !== w || bus_a.o_Data !== exp_data[w]) begin
            n_fail++;
            $display("FAIL rr_beat[%0d]: gnt=%b vld=%b src=%0d data=%h, required 0000/1/%0d/%h",
                     i, bus_a.o_Gnt, bus_a.o_Valid, bus_a.o_Src, bus_a.o_Data, w, exp_data[w]);
         end
      end
      bus_a.i_Req = 4'b0000;
   endtask

   task automatic test_burst_stall();
      do_reset();
      bus_a.i_Req = 4'b0100; bus_a.i_Last = 4'b0000; bus_a.i_Data3 = 8'h11; bus_a.i_Ready = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus_a.o_Data !== 8'h11 || bus_a.o_Valid !== 1'b1 || bus_a.o_Src !== 2'd2 || bus_a.o_Gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL burst_beat1: data=%h vld=%b src=%0d gnt=%b, required 11/1/2/0100",
                  bus_a.o_Data, bus_a.o_Valid, bus_a.o_Src, bus_a.o_Gnt);
      end
      bus_a.i_Ready = 1'b0; bus_a.i_Data3 = 8'h22;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (bus_a.o_Data !== 8'h11 || bus_a.o_Valid !== 1'b1 || bus_a.o_Gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL burst_stall[%0d]: data=%h vld=%b gnt=%b, required 11/1/0100",
                     i, bus_a.o_Data, bus_a.o_Valid, bus_a.o_Gnt);
         end
      end
      bus_a.i_Ready = 1'b1;
      tick();
      n_checks++;
      if (bus_a.o_Data !== 8'h22 || bus_a.o_Valid !== 1'b1 || bus_a.o_Gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL burst_beat2: data=%h vld=%b gnt=%b, required 22/1/0100", bus_a.o_Data, bus_a.o_Valid, bus_a.o_Gnt);
      end
      bus_a.i_Data3 = 8'h33; bus_a.i_Last = 4'b0100;
      tick();
      n_checks++;
      if (bus_a.o_Data !== 8'h33 || bus_a.o_Valid !== 1'b1 || bus_a.o_Gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL burst_beat3: data=%h vld=%b gnt=%b, required 33/1/0000", bus_a.o_Data, bus_a.o_Valid, bus_a.o_Gnt);
      end
      bus_a.i_Req = 4'b0000; bus_a.i_Last = 4'b0000;
   endtask

   task automatic test_watchdog();
      do_reset();
      bus_b.i_Req = 4'b0010; bus_b.i_Last = 4'b0000; bus_b.i_Data2 = 8'h77; bus_b.i_Ready = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus_b.o_Valid !== 1'b1 || bus_b.o_Data !== 8'h77 || bus_b.o_Gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL wd_first_beat: vld=%b data=%h gnt=%b, required 1/77/0010", bus_b.o_Valid, bus_b.o_Data, bus_b.o_Gnt);
      end
      bus_b.i_Ready = 1'b0; bus_b.i_Req = 4'b0110;
      tick();
      tick();
      n_checks++;
      if (bus_b.o_Timeout !== 1'b0 || bus_b.o_Gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL wd_before_limit: to=%b gnt=%b, required 0/0010", bus_b.o_Timeout, bus_b.o_Gnt);
      end
      tick();
      n_checks++;
      if (bus_b.o_Timeout !== 1'b1 || bus_b.o_Gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL wd_release: to=%b gnt=%b, required 1/0000", bus_b.o_Timeout, bus_b.o_Gnt);
      end
      tick();
      n_checks++;
      if (bus_b.o_Timeout !== 1'b0 || bus_b.o_Gnt !== 4'b0100 || bus_b.o_Data !== 8'h77 || bus_b.o_Valid !== 1'b1) begin
         n_fail++;
         $display("FAIL wd_next_grant: to=%b gnt=%b data=%h vld=%b, required 0/0100/77/1",
                  bus_b.o_Timeout, bus_b.o_Gnt, bus_b.o_Data, bus_b.o_Valid);
      end
      bus_b.i_Req = 4'b0000;
   endtask

   task automatic test_async_reset();
      do_reset();
      bus_a.i_Req = 4'b1111; bus_a.i_Last = 4'b0000; bus_a.i_Ready = 1'b1; bus_a.i_Data1 = 8'hC3;
      tick();
      tick();
      n_checks++;
      if (bus_a.o_Valid !== 1'b1 || bus_a.o_Data !== 8'hC3 || bus_a.o_Gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL ar_pre: vld=%b data=%h gnt=%b, required 1/c3/0001", bus_a.o_Valid, bus_a.o_Data, bus_a.o_Gnt);
      end
      #2;
      rst_b = 1'b0;
      #1;
      n_checks++;
      if ({bus_a.o_Gnt, bus_a.o_Select, bus_a.o_Valid, bus_a.o_Data, bus_a.o_Src, bus_a.o_Timeout} !== 18'h0) begin
         n_fail++;
         $display("FAIL ar_immediate: gnt=%b vld=%b data=%h, required all zero", bus_a.o_Gnt, bus_a.o_Valid, bus_a.o_Data);
      end
      #1;
      rst_b = 1'b1;
      tick();
      n_checks++;
      if (bus_a.o_Gnt !== 4'b0001 || bus_a.o_Valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_first_grant: gnt=%b vld=%b, required 0001/0", bus_a.o_Gnt, bus_a.o_Valid);
      end
      bus_a.i_Req = 4'b0000;
   endtask

   task automatic test_drop();
      do_reset();
      bus_a.i_Req = 4'b1000; bus_a.i_Ready = 1'b1; bus_a.i_Data4 = 8'hEE;
      tick();
      n_checks++;
      if (bus_a.o_Gnt !== 4'b1000 || bus_a.o_Select !== 2'd3) begin
         n_fail++;
         $display("FAIL drop_grant: gnt=%b sel=%0d, required 1000/3", bus_a.o_Gnt, bus_a.o_Select);
      end
      bus_a.i_Req = 4'b0000;
      tick();
      n_checks++;
      if (bus_a.o_Gnt !== 4'b0000 || bus_a.o_Valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_release: gnt=%b vld=%b, required 0000/0", bus_a.o_Gnt, bus_a.o_Valid);
      end
      bus_a.i_Req = 4'b1001;
      tick();
      n_checks++;
      if (bus_a.o_Gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL drop_ptr_wrap: gnt=%b, required 0001", bus_a.o_Gnt);
      end
      bus_a.i_Req = 4'b0000;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_b    = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_burst_stall();
      test_watchdog();
      test_async_reset();
      test_drop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
